// File: rtl/sram_bus_ctrl_if.sv
// Bus bundle between a 68000-style CPU, the SRAM controller and an asynchronous SRAM.
// The controller takes the slave modport; the CPU/SRAM side takes master.
interface sram_bus_ctrl_if;
    logic [22:0] cpu_addr;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_dout_oe;
    logic        cpu_dtack_n;

    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport slave (
        input  cpu_addr, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_din, sram_dq_in,
        output cpu_dout, cpu_dout_oe, cpu_dtack_n,
        output sram_addr, sram_dq_out, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output cpu_addr, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_din, sram_dq_in,
        input  cpu_dout, cpu_dout_oe, cpu_dtack_n,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Asynchronous 68000 bus to asynchronous SRAM bridge with a 2 MB decode window.
// Every output comes straight from a register; decisions use the synchronized address strobe.
module sram_bus_ctrl #(
    parameter logic [2:0]  BASE        = 3'b000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    sram_bus_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, RELEASE} state_t;

    typedef struct packed {
        logic        dtack_n;
        logic        dout_oe;
        logic [15:0] dout;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        ub_n;
        logic        lb_n;
        logic        dq_oe;
        logic [19:0] addr;
        logic [15:0] dq_out;
        logic        rw;
        logic [3:0]  cnt;
    } regs_t;

    localparam regs_t RESET_REGS = '{
        dtack_n: 1'b1, dout_oe: 1'b0, dout: 16'h0000,
        ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0,
        addr: 20'h00000, dq_out: 16'h0000, rw: 1'b1, cnt: 4'd0
    };

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t     state_q, state_d;
    regs_t      r_q, r_d;
    logic [1:0] as_sync;
    logic       as_s;
    logic       hit;
    logic       req;

    // cpu_as_n is asynchronous; the other CPU inputs are stable while it is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_sync <= 2'b11;
        end else begin
            as_sync <= {as_sync[0], bus.cpu_as_n};
        end
    end

    assign as_s = as_sync[1];
    assign hit  = (bus.cpu_addr[22:20] == BASE);
    assign req  = !as_s && (!bus.cpu_uds_n || !bus.cpu_lds_n) && hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= RESET_REGS;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    // r_d is the value every output register takes at the next edge.
    always_comb begin
        // NOTE: defaults first, so every path assigns every bit and no latch is inferred.
        state_d = state_q;
        r_d     = r_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    r_d.addr   = bus.cpu_addr[19:0];
                    r_d.rw     = bus.cpu_rw;
                    r_d.ub_n   = bus.cpu_uds_n;
                    r_d.lb_n   = bus.cpu_lds_n;
                    r_d.dq_out = bus.cpu_din;
                    r_d.ce_n   = 1'b0;
                    r_d.oe_n   = !bus.cpu_rw;
                    r_d.dq_oe  = !bus.cpu_rw;
                    r_d.we_n   = 1'b1;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                if (as_s) begin
                    r_d.ce_n  = 1'b1;
                    r_d.oe_n  = 1'b1;
                    r_d.we_n  = 1'b1;
                    r_d.dq_oe = 1'b0;
                    r_d.ub_n  = 1'b1;
                    r_d.lb_n  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    r_d.cnt  = CNT_LOAD;
                    r_d.we_n = r_q.rw;
                    state_d  = ACCESS;
                end
            end

            ACCESS: begin
                if (as_s) begin
                    r_d.ce_n  = 1'b1;
                    r_d.oe_n  = 1'b1;
                    r_d.we_n  = 1'b1;
                    r_d.dq_oe = 1'b0;
                    r_d.ub_n  = 1'b1;
                    r_d.lb_n  = 1'b1;
                    state_d   = IDLE;
                end else if (r_q.cnt == 4'd1) begin
                    // The SRAM output is still enabled here, so the read data is valid.
                    if (r_q.rw) begin
                        r_d.dout = bus.sram_dq_in;
                    end
                    r_d.dtack_n = 1'b0;
                    r_d.dout_oe = r_q.rw;
                    r_d.oe_n    = 1'b1;
                    r_d.we_n    = 1'b1;
                    state_d     = DONE;
                end else begin
                    r_d.cnt = r_q.cnt - 4'd1;
                end
            end

            DONE: begin
                state_d = RELEASE;
            end

            RELEASE: begin
                if (as_s) begin
                    r_d.dtack_n = 1'b1;
                    r_d.dout_oe = 1'b0;
                    r_d.ce_n    = 1'b1;
                    r_d.dq_oe   = 1'b0;
                    r_d.ub_n    = 1'b1;
                    r_d.lb_n    = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                r_d     = RESET_REGS;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cpu_dout    = r_q.dout;
    assign bus.cpu_dout_oe = r_q.dout_oe;
    assign bus.cpu_dtack_n = r_q.dtack_n;
    assign bus.sram_addr   = r_q.addr;
    assign bus.sram_dq_out = r_q.dq_out;
    assign bus.sram_dq_oe  = r_q.dq_oe;
    assign bus.sram_ce_n   = r_q.ce_n;
    assign bus.sram_oe_n   = r_q.oe_n;
    assign bus.sram_we_n   = r_q.we_n;
    assign bus.sram_ub_n   = r_q.ub_n;
    assign bus.sram_lb_n   = r_q.lb_n;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: reads, word/byte writes, miss, abort and mid-access reset.
// A behavioural SRAM and edge-counting monitors supply the observed side.
module tb_sram_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    sram_bus_ctrl_if bus ();

    sram_bus_ctrl #(.BASE(3'b000), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // SRAM model and monitors, all evaluated at the falling edge.
    logic [15:0] mem [logic [19:0]];
    bit          preloaded = 1'b0;
    int          we_lo_cnt = 0;
    int          ce_lo_cnt = 0;
    int          dtack_cnt = 0;
    int          excl_err  = 0;
    logic [15:0] we_dq;
    logic        we_ub;
    logic        we_lb;

    always @(negedge clk) begin
        if (!preloaded) begin
            mem[20'h00123] = 16'hBEEF;
            mem[20'h00055] = 16'h1122;
            preloaded = 1'b1;
        end
        if (!bus.sram_ce_n && !bus.sram_oe_n && mem.exists(bus.sram_addr))
            bus.sram_dq_in = mem[bus.sram_addr];
        else
            bus.sram_dq_in = 16'h0000;
        if (!bus.sram_ce_n && !bus.sram_we_n) begin
            logic [15:0] w;
            w = mem.exists(bus.sram_addr) ? mem[bus.sram_addr] : 16'h0000;
            if (!bus.sram_ub_n) w[15:8] = bus.sram_dq_out[15:8];
            if (!bus.sram_lb_n) w[7:0]  = bus.sram_dq_out[7:0];
            mem[bus.sram_addr] = w;
        end
        if (!bus.sram_we_n) begin
            we_lo_cnt = we_lo_cnt + 1;
            we_dq = bus.sram_dq_out;
            we_ub = bus.sram_ub_n;
            we_lb = bus.sram_lb_n;
        end
        if (!bus.sram_ce_n)   ce_lo_cnt = ce_lo_cnt + 1;
        if (!bus.cpu_dtack_n) dtack_cnt = dtack_cnt + 1;
        if (!bus.sram_we_n && !bus.sram_oe_n) excl_err = excl_err + 1;
        if (!bus.sram_oe_n && bus.sram_dq_oe)  excl_err = excl_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [22:0] a, input logic rw, input logic [15:0] d,
                             input logic u, input logic l);
        @(negedge clk);
        bus.cpu_addr  = a;
        bus.cpu_rw    = rw;
        bus.cpu_din   = d;
        bus.cpu_uds_n = u;
        bus.cpu_lds_n = l;
        bus.cpu_as_n  = 1'b0;
    endtask

    task automatic end_req();
        @(negedge clk);
        bus.cpu_as_n  = 1'b1;
        bus.cpu_uds_n = 1'b1;
        bus.cpu_lds_n = 1'b1;
    endtask

    // Edge 1 is the first rising edge after the strobe goes low; -1 means no dtack.
    task automatic wait_dtack(output int edge_n);
        edge_n = -1;
        for (int i = 1; i <= 40 && edge_n < 0; i++) begin
            @(posedge clk);
            #1;
            if (!bus.cpu_dtack_n) edge_n = i;
        end
    endtask

    task automatic do_cycle(input logic [22:0] a, input logic rw, input logic [15:0] d,
                            input logic u, input logic l, input string tag,
                            output int edge_n, output logic [15:0] dout, output logic dout_oe);
        int k;
        start_req(a, rw, d, u, l);
        wait_dtack(edge_n);
        dout    = bus.cpu_dout;
        dout_oe = bus.cpu_dout_oe;
        end_req();
        k = 0;
        while (!bus.cpu_dtack_n && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_rel_dtack"}, 32'(bus.cpu_dtack_n), 32'd1);
        check({tag, "_rel_ce"},    32'(bus.sram_ce_n),   32'd1);
        check({tag, "_rel_oe"},    32'(bus.cpu_dout_oe), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int          e;
        logic [15:0] dout;
        logic        doe;
        int          snap_we, snap_ce, snap_dt;

        bus.cpu_addr  = '0;
        bus.cpu_as_n  = 1'b1;
        bus.cpu_uds_n = 1'b1;
        bus.cpu_lds_n = 1'b1;
        bus.cpu_rw    = 1'b1;
        bus.cpu_din   = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dtack",  32'(bus.cpu_dtack_n), 32'd1);
        check("rst_doe",    32'(bus.cpu_dout_oe), 32'd0);
        check("rst_dout",   32'(bus.cpu_dout),    32'h0);
        check("rst_ctl",    32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}), 32'h1f);
        check("rst_dq_oe",  32'(bus.sram_dq_oe),  32'd0);
        check("rst_addr",   32'(bus.sram_addr),   32'h0);
        check("rst_dq_out", 32'(bus.sram_dq_out), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Word read
        do_cycle(23'h000123, 1'b1, 16'h0000, 1'b0, 1'b0, "rd1", e, dout, doe);
        check("rd1_edge", 32'(e), 32'd6);
        check("rd1_data", 32'(dout), 32'hBEEF);
        check("rd1_doe",  32'(doe), 32'd1);

        // Word write and readback
        snap_we = we_lo_cnt;
        do_cycle(23'h00ABCD, 1'b0, 16'h1234, 1'b0, 1'b0, "wr1", e, dout, doe);
        check("wr1_edge",   32'(e), 32'd6);
        check("wr1_doe",    32'(doe), 32'd0);
        check("wr1_we_len", 32'(we_lo_cnt - snap_we), 32'd2);
        check("wr1_dq",     32'(we_dq), 32'h1234);
        check("wr1_mem",    32'(mem[20'h0ABCD]), 32'h1234);
        do_cycle(23'h00ABCD, 1'b1, 16'h0000, 1'b0, 1'b0, "rb1", e, dout, doe);
        check("rb1_data", 32'(dout), 32'h1234);

        // Upper-byte write over 0x1122
        do_cycle(23'h000055, 1'b0, 16'hAA55, 1'b0, 1'b1, "bw", e, dout, doe);
        check("bw_ub",  32'(we_ub), 32'd0);
        check("bw_lb",  32'(we_lb), 32'd1);
        check("bw_mem", 32'(mem[20'h00055]), 32'hAA22);
        do_cycle(23'h000055, 1'b1, 16'h0000, 1'b0, 1'b0, "bwrb", e, dout, doe);
        check("bwrb_data", 32'(dout), 32'hAA22);

        // Address miss: no response for 20 cycles
        snap_ce = ce_lo_cnt;
        snap_dt = dtack_cnt;
        start_req(23'h200000, 1'b1, 16'h0000, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        check("miss_ce",    32'(ce_lo_cnt - snap_ce), 32'd0);
        check("miss_dtack", 32'(dtack_cnt - snap_dt), 32'd0);
        end_req();

        // Hit with both byte strobes high: stays idle
        start_req(23'h000123, 1'b1, 16'h0000, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        check("nostb_ce", 32'(ce_lo_cnt - snap_ce), 32'd0);
        end_req();
        repeat (3) @(posedge clk);

        // Abort a write while in ACCESS
        snap_dt = dtack_cnt;
        start_req(23'h000300, 1'b0, 16'h5A5A, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) bus.cpu_as_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ab_we_active", 32'(bus.sram_we_n), 32'd0);
        @(posedge clk);
        #1;
        check("ab_ctl",   32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}), 32'h7);
        check("ab_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        end_req();
        repeat (10) @(posedge clk);
        check("ab_dtack", 32'(dtack_cnt - snap_dt), 32'd0);
        do_cycle(23'h000123, 1'b1, 16'h0000, 1'b0, 1'b0, "abrd", e, dout, doe);
        check("abrd_edge", 32'(e), 32'd6);
        check("abrd_data", 32'(dout), 32'hBEEF);

        // Reset during a write in ACCESS
        start_req(23'h000400, 1'b0, 16'hC3C3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("rs_we_active", 32'(bus.sram_we_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rs_ctl",    32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}), 32'h1f);
        check("rs_dtack",  32'(bus.cpu_dtack_n), 32'd1);
        check("rs_dout",   32'(bus.cpu_dout),    32'h0);
        check("rs_addr",   32'(bus.sram_addr),   32'h0);
        check("rs_dq",     32'({bus.sram_dq_oe, bus.sram_dq_out}), 32'h0);
        end_req();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_cycle(23'h000055, 1'b1, 16'h0000, 1'b0, 1'b0, "rsrd", e, dout, doe);
        check("rsrd_edge", 32'(e), 32'd6);
        check("rsrd_data", 32'(dout), 32'hAA22);

        check("we_oe_excl", 32'(excl_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
